// File: rtl/cia_ports_hs.sv
// cia_ports_hs - parametrised CIA-style parallel-port block.
//
// Provides NPORTS ports of W bits. Each port has a PR (output data)
// register, a DDR (direction) register, a LAT (latched input) register and
// a CTRL register {FLG, .., IE, PCM, LE}. The block also provides per-port
// FLAG falling-edge capture, a /PC strobe (pulse or handshake mode), a timer
// override on the top two bits of TMR_PORT, and an interrupt request.
//
// Ports:
//   clk, res_n        clock, asynchronous active-low reset
//   phi2_up, phi2_dn  one-clk pulses marking the PHI2 rising and falling edges
//   rd, we, addr      bus cycle qualifiers; addr = {port index, sel}
//                     sel: 0=PR 1=DDR 2=LAT 3=CTRL
//   data, rdata       write data; read data (combinational on addr)
//   port_in           pad inputs, port p at [p*W +: W]
//   flag_n            per-port FLAG inputs, active-low
//   tmr_pb, tmr_on    timer outputs {B, A} and their enables
//   pad_out, pad_oe   pad output values and output enables
//   pc_n, irq_n       /PC strobe and interrupt request, both active-low
module cia_ports_hs #(
  parameter int NPORTS   = 2,
  parameter int W        = 8,
  parameter int PC_PORT  = 1,
  parameter int TMR_PORT = 1,
  parameter int AW       = ((NPORTS > 1) ? $clog2(NPORTS) : 0) + 2
) (
  input  logic                clk,
  input  logic                res_n,
  input  logic                phi2_up,
  input  logic                phi2_dn,
  input  logic                rd,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic [W-1:0]        data,
  output logic [W-1:0]        rdata,
  input  logic [NPORTS*W-1:0] port_in,
  input  logic [NPORTS-1:0]   flag_n,
  input  logic [1:0]          tmr_pb,
  input  logic [1:0]          tmr_on,
  output logic [NPORTS*W-1:0] pad_out,
  output logic [NPORTS*W-1:0] pad_oe,
  output logic                pc_n,
  output logic                irq_n
);

  logic [W-1:0]      r_pr   [NPORTS];
  logic [W-1:0]      r_ddr  [NPORTS];
  logic [W-1:0]      r_lat  [NPORTS];
  logic [W-1:0]      r_inq  [NPORTS];
  logic [2:0]        r_ctrl [NPORTS];
  logic [NPORTS-1:0] r_flg;
  logic [NPORTS-1:0] r_fs;
  logic [2:0]        r_rw;
  logic              r_hs;
  logic              r_irq_n;

  int                w_idx;
  logic [1:0]        w_sel;
  logic              w_wr;
  logic              w_rdclr;
  logic              w_acc;
  logic              w_pcm;
  logic              w_pcm_chg;
  logic [NPORTS-1:0] w_fall;
  logic [NPORTS-1:0] w_ie;
  logic [W-1:0]      w_rd_val;

  // Full-width address decode: the index is everything above the sel bits.
  assign w_idx   = int'(addr >> 2);
  assign w_sel   = addr[1:0];
  assign w_wr    = phi2_dn & we;
  assign w_rdclr = phi2_dn & rd & (w_sel == 2'd3);
  assign w_acc   = (rd | we) & (addr == AW'(PC_PORT * 4));
  // w_fall is only meaningful in the clk where phi2_up is high.
  assign w_fall  = r_fs & ~flag_n;
  assign w_pcm   = r_ctrl[PC_PORT][1];
  // Any write that flips PCM on the /PC port restarts the strobe logic.
  assign w_pcm_chg = w_wr & (w_idx == PC_PORT) & (w_sel == 2'd3) & (data[1] != w_pcm);

  // Per-port PR/DDR/CTRL writes and input/latch sampling.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int p = 0; p < NPORTS; p++) begin
        r_pr[p]   <= '0;
        r_ddr[p]  <= '0;
        r_lat[p]  <= '0;
        r_inq[p]  <= '0;
        r_ctrl[p] <= 3'b000;
      end
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (w_wr && (w_idx == p)) begin
          case (w_sel)
            2'd0:    r_pr[p]   <= data;
            2'd1:    r_ddr[p]  <= data;
            2'd3:    r_ctrl[p] <= data[2:0];
            default: ;
          endcase
        end
        if (phi2_up) begin
          r_inq[p] <= port_in[p*W +: W];
          // With LE set the latch only opens on a FLAG falling edge.
          if (!r_ctrl[p][0] || w_fall[p]) begin
            r_lat[p] <= port_in[p*W +: W];
          end
        end
      end
    end
  end

  // FLAG sampling and FLG set/clear; a set always beats a clear in the same clk.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_fs  <= '1;
      r_flg <= '0;
    end else begin
      if (phi2_up) begin
        r_fs <= flag_n;
      end
      for (int p = 0; p < NPORTS; p++) begin
        if (phi2_up && w_fall[p]) begin
          r_flg[p] <= 1'b1;
        end else if (w_rdclr && (w_idx == p)) begin
          r_flg[p] <= 1'b0;
        end
      end
    end
  end

  // /PC strobe state: access shifter in pulse mode, hs flag in handshake mode.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_rw <= 3'b000;
      r_hs <= 1'b0;
    end else if (w_pcm_chg) begin
      r_rw <= 3'b000;
      r_hs <= 1'b0;
    end else if (!w_pcm) begin
      if (phi2_dn) begin
        r_rw <= {r_rw[1:0], w_acc};
      end
    end else begin
      // The FLAG edge that acknowledges the handshake wins over a new access.
      if (phi2_up && w_fall[PC_PORT]) begin
        r_hs <= 1'b0;
      end else if (phi2_dn && w_acc) begin
        r_hs <= 1'b1;
      end
    end
  end

  // Interrupt request register.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_irq_n <= 1'b1;
    end else begin
      r_irq_n <= ~|(r_flg & w_ie);
    end
  end

  // Collect per-port IE bits.
  always_comb begin
    w_ie = '0;
    for (int p = 0; p < NPORTS; p++) begin
      w_ie[p] = r_ctrl[p][2];
    end
  end

  // Read mux; an index with no port behind it reads as zero.
  always_comb begin
    rdata    = '0;
    w_rd_val = '0;
    for (int p = 0; p < NPORTS; p++) begin
      case (w_sel)
        2'd0: w_rd_val = r_inq[p];
        2'd1: w_rd_val = r_ddr[p];
        2'd2: w_rd_val = r_lat[p];
        2'd3: begin
          w_rd_val        = W'(r_ctrl[p]);
          w_rd_val[W-1]   = r_flg[p];
        end
        default: w_rd_val = '0;
      endcase
      rdata = rdata | ({W{w_idx == p}} & w_rd_val);
    end
  end

  // Pad drivers, with the timer outputs overriding the top two bits of TMR_PORT.
  always_comb begin
    pad_out = '0;
    pad_oe  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      pad_out[p*W +: W] = r_pr[p];
      pad_oe[p*W +: W]  = r_ddr[p];
    end
    pad_out[TMR_PORT*W + W-1] = tmr_on[1] ? tmr_pb[1] : r_pr[TMR_PORT][W-1];
    pad_oe[TMR_PORT*W + W-1]  = tmr_on[1] | r_ddr[TMR_PORT][W-1];
    pad_out[TMR_PORT*W + W-2] = tmr_on[0] ? tmr_pb[0] : r_pr[TMR_PORT][W-2];
    pad_oe[TMR_PORT*W + W-2]  = tmr_on[0] | r_ddr[TMR_PORT][W-2];
  end

  // Pulse mode: low while the newest access is present and the one two phi2
  // cycles back was absent, giving 1 cycle, or 2 for back-to-back accesses.
  assign pc_n  = w_pcm ? ~r_hs : ~(r_rw[0] & ~r_rw[2]);
  assign irq_n = r_irq_n;

endmodule
